// File: rtl/alu_exec.sv
// ----------------------------------------------------------------------------
// alu_exec -- ARM-style data-processing execute stage.
//
// Accepts one data-processing instruction per cycle, evaluates its condition
// field against the stage's own NZCV register, computes the ALU result and
// holds it in a single-entry output register until writeback takes it.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid && ready are both 1. The producer holds its payload stable while
// valid && !ready. in_ready is combinational:
//   in_ready = !rst && (!out_valid || out_ready)
// so a held entry drains and a new one is accepted on the same edge.
//
// Ports
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   in_valid     upstream offers an instruction
//   in_ready     stage can accept an instruction this cycle
//   opcode       ARM data-processing opcode (AND .. MVN)
//   s_bit        update flags when 1 (compare opcodes always update)
//   cond         ARM condition field
//   rn_val       first operand (Rn)
//   operand2     second operand from the barrel shifter
//   shift_carry  shifter carry-out, becomes C for logical opcodes
//   rd_addr      destination register index
//   out_valid    output register holds a valid entry
//   out_ready    writeback accepts the entry
//   result       registered ALU result (0 when the condition failed)
//   wb_en        result is to be written to wb_addr
//   wb_addr      registered rd_addr
//   flags        NZCV register, N in bit 3
// ----------------------------------------------------------------------------
module alu_exec #(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [3:0]   opcode,
    input  logic         s_bit,
    input  logic [3:0]   cond,
    input  logic [n-1:0] rn_val,
    input  logic [n-1:0] operand2,
    input  logic         shift_carry,
    input  logic [3:0]   rd_addr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] result,
    output logic         wb_en,
    output logic [3:0]   wb_addr,
    output logic [3:0]   flags
);

    // Opcode encodings
    localparam logic [3:0] op_and = 4'h0;
    localparam logic [3:0] op_eor = 4'h1;
    localparam logic [3:0] op_sub = 4'h2;
    localparam logic [3:0] op_rsb = 4'h3;
    localparam logic [3:0] op_add = 4'h4;
    localparam logic [3:0] op_adc = 4'h5;
    localparam logic [3:0] op_sbc = 4'h6;
    localparam logic [3:0] op_rsc = 4'h7;
    localparam logic [3:0] op_tst = 4'h8;
    localparam logic [3:0] op_teq = 4'h9;
    localparam logic [3:0] op_cmp = 4'hA;
    localparam logic [3:0] op_cmn = 4'hB;
    localparam logic [3:0] op_orr = 4'hC;
    localparam logic [3:0] op_mov = 4'hD;
    localparam logic [3:0] op_bic = 4'hE;
    localparam logic [3:0] op_mvn = 4'hF;

    // Condition encodings
    localparam logic [3:0] cc_eq = 4'h0;
    localparam logic [3:0] cc_ne = 4'h1;
    localparam logic [3:0] cc_cs = 4'h2;
    localparam logic [3:0] cc_cc = 4'h3;
    localparam logic [3:0] cc_mi = 4'h4;
    localparam logic [3:0] cc_pl = 4'h5;
    localparam logic [3:0] cc_vs = 4'h6;
    localparam logic [3:0] cc_vc = 4'h7;
    localparam logic [3:0] cc_hi = 4'h8;
    localparam logic [3:0] cc_ls = 4'h9;
    localparam logic [3:0] cc_ge = 4'hA;
    localparam logic [3:0] cc_lt = 4'hB;
    localparam logic [3:0] cc_gt = 4'hC;
    localparam logic [3:0] cc_le = 4'hD;
    localparam logic [3:0] cc_al = 4'hE;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic transfer;

    assign in_ready = !rst && (!out_valid || out_ready);
    assign transfer = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Condition evaluation against the current flag register
    // ------------------------------------------------------------------
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_pass;

    assign flag_n = flags[3];
    assign flag_z = flags[2];
    assign flag_c = flags[1];
    assign flag_v = flags[0];

    always_comb begin
        cond_pass = 1'b0;
        case (cond)
            cc_eq:   cond_pass = flag_z;
            cc_ne:   cond_pass = !flag_z;
            cc_cs:   cond_pass = flag_c;
            cc_cc:   cond_pass = !flag_c;
            cc_mi:   cond_pass = flag_n;
            cc_pl:   cond_pass = !flag_n;
            cc_vs:   cond_pass = flag_v;
            cc_vc:   cond_pass = !flag_v;
            cc_hi:   cond_pass = flag_c && !flag_z;
            cc_ls:   cond_pass = !flag_c || flag_z;
            cc_ge:   cond_pass = (flag_n == flag_v);
            cc_lt:   cond_pass = (flag_n != flag_v);
            cc_gt:   cond_pass = !flag_z && (flag_n == flag_v);
            cc_le:   cond_pass = flag_z || (flag_n != flag_v);
            cc_al:   cond_pass = 1'b1;
            default: cond_pass = 1'b0;   // 0xF never executes
        endcase
    end

    // ------------------------------------------------------------------
    // Shared adder: every arithmetic opcode is add_a + add_b + add_cin.
    // Subtractions feed the inverted subtrahend, so the carry-out is the
    // ARM "not borrow" and V comes from the adder's actual inputs.
    // ------------------------------------------------------------------
    logic [n-1:0] add_a;
    logic [n-1:0] add_b;
    logic         add_cin;
    logic         is_arith;
    logic [n:0]   sum;

    always_comb begin
        add_a    = rn_val;
        add_b    = operand2;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (opcode)
            op_sub, op_cmp: begin
                add_a   = rn_val;
                add_b   = ~operand2;
                add_cin = 1'b1;
            end
            op_rsb: begin
                add_a   = operand2;
                add_b   = ~rn_val;
                add_cin = 1'b1;
            end
            op_add, op_cmn: begin
                add_a   = rn_val;
                add_b   = operand2;
                add_cin = 1'b0;
            end
            op_adc: begin
                add_a   = rn_val;
                add_b   = operand2;
                add_cin = flag_c;
            end
            op_sbc: begin
                add_a   = rn_val;
                add_b   = ~operand2;
                add_cin = flag_c;
            end
            op_rsc: begin
                add_a   = operand2;
                add_b   = ~rn_val;
                add_cin = flag_c;
            end
            default: is_arith = 1'b0;
        endcase
    end

    assign sum = {1'b0, add_a} + {1'b0, add_b} + {{n{1'b0}}, add_cin};

    // ------------------------------------------------------------------
    // Logical unit
    // ------------------------------------------------------------------
    logic [n-1:0] logic_res;

    always_comb begin
        logic_res = '0;
        case (opcode)
            op_and, op_tst: logic_res = rn_val & operand2;
            op_eor, op_teq: logic_res = rn_val ^ operand2;
            op_orr:         logic_res = rn_val | operand2;
            op_mov:         logic_res = operand2;
            op_bic:         logic_res = rn_val & ~operand2;
            op_mvn:         logic_res = ~operand2;
            default:        logic_res = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // Result and next flags
    // ------------------------------------------------------------------
    logic [n-1:0] alu_res;
    logic         res_c;
    logic         res_v;
    logic [3:0]   next_flags;
    logic         is_compare;
    logic         update_flags;

    assign alu_res = is_arith ? sum[n-1:0] : logic_res;

    // Logical opcodes take C from the shifter and keep the old V.
    assign res_c = is_arith ? sum[n] : shift_carry;
    assign res_v = is_arith ? ((add_a[n-1] == add_b[n-1]) && (sum[n-1] != add_a[n-1]))
                            : flag_v;

    assign next_flags = {alu_res[n-1], (alu_res == '0), res_c, res_v};

    // TST/TEQ/CMP/CMN (8..B) always set flags and never write back.
    assign is_compare   = (opcode[3:2] == 2'b10);
    assign update_flags = cond_pass && (s_bit || is_compare);

    // ------------------------------------------------------------------
    // Output register and flag register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            wb_en     <= 1'b0;
            wb_addr   <= 4'd0;
            flags     <= 4'b0000;
        end else begin
            if (transfer) begin
                // A failed condition still occupies the slot, as a no-op.
                out_valid <= 1'b1;
                result    <= cond_pass ? alu_res : '0;
                wb_en     <= cond_pass && !is_compare;
                wb_addr   <= rd_addr;
                if (update_flags) begin
                    flags <= next_flags;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
// ----------------------------------------------------------------------------
// tb_alu_exec -- self-checking bench for alu_exec.
// Directed vector table, hand-written stall/reset sequences, then a random
// phase scored against a reference model built on wide integer arithmetic.
// ----------------------------------------------------------------------------
module tb_alu_exec;

    localparam int n = 32;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   opcode;
    logic         s_bit;
    logic [3:0]   cond;
    logic [n-1:0] rn_val;
    logic [n-1:0] operand2;
    logic         shift_carry;
    logic [3:0]   rd_addr;
    logic         out_valid;
    logic         out_ready;
    logic [n-1:0] result;
    logic         wb_en;
    logic [3:0]   wb_addr;
    logic [3:0]   flags;

    always #5 clk = ~clk;

    alu_exec #(.n(n)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .opcode      (opcode),
        .s_bit       (s_bit),
        .cond        (cond),
        .rn_val      (rn_val),
        .operand2    (operand2),
        .shift_carry (shift_carry),
        .rd_addr     (rd_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .flags       (flags)
    );

    // ------------------------------------------------------------------
    // Check bookkeeping
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic drive(input logic [3:0] op, input logic s, input logic [3:0] cd,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic sc, input logic [3:0] rd);
        opcode      = op;
        s_bit       = s;
        cond        = cd;
        rn_val      = a;
        operand2    = b;
        shift_carry = sc;
        rd_addr     = rd;
    endtask

    // ------------------------------------------------------------------
    // Reference model: arithmetic done on 64-bit integers, carry read as
    // "no borrow" / "sum exceeds 2^32", overflow as "signed result out of
    // 32-bit range".
    // ------------------------------------------------------------------
    function automatic void ref_model(
        input  logic [3:0]  op, input logic s, input logic [3:0] cd,
        input  logic [31:0] a,  input logic [31:0] b, input logic sc,
        input  logic [3:0]  f,
        output logic [31:0] res, output logic wb, output logic [3:0] nf);
        logic fn, fz, fc, fv, pass, cmp, arith, is_add, c_new, v_new;
        logic [31:0] r;
        longint ua, ub, sa, sb, u, sv, bi;
        {fn, fz, fc, fv} = f;
        case (cd)
            4'h0: pass = fz;
            4'h1: pass = !fz;
            4'h2: pass = fc;
            4'h3: pass = !fc;
            4'h4: pass = fn;
            4'h5: pass = !fn;
            4'h6: pass = fv;
            4'h7: pass = !fv;
            4'h8: pass = fc && !fz;
            4'h9: pass = !fc || fz;
            4'hA: pass = (fn == fv);
            4'hB: pass = (fn != fv);
            4'hC: pass = !fz && (fn == fv);
            4'hD: pass = fz || (fn != fv);
            4'hE: pass = 1'b1;
            default: pass = 1'b0;
        endcase
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        bi = fc ? 0 : 1;
        u = 0; sv = 0; r = 0;
        arith  = 1'b1;
        is_add = 1'b0;
        case (op)
            4'h0, 4'h8: begin r = a & b;  arith = 1'b0; end
            4'h1, 4'h9: begin r = a ^ b;  arith = 1'b0; end
            4'hC:       begin r = a | b;  arith = 1'b0; end
            4'hD:       begin r = b;      arith = 1'b0; end
            4'hE:       begin r = a & ~b; arith = 1'b0; end
            4'hF:       begin r = ~b;     arith = 1'b0; end
            4'h2, 4'hA: begin u = ua - ub;      sv = sa - sb;      end
            4'h3:       begin u = ub - ua;      sv = sb - sa;      end
            4'h6:       begin u = ua - ub - bi; sv = sa - sb - bi; end
            4'h7:       begin u = ub - ua - bi; sv = sb - sa - bi; end
            4'h4, 4'hB: begin u = ua + ub; sv = sa + sb; is_add = 1'b1; end
            default:    begin u = ua + ub + (fc ? 1 : 0); sv = sa + sb + (fc ? 1 : 0); is_add = 1'b1; end
        endcase
        if (arith) begin
            r     = u[31:0];
            c_new = is_add ? (u >= 64'sh1_0000_0000) : (u >= 0);
            v_new = (sv > 64'sd2147483647) || (sv < -64'sd2147483648);
        end else begin
            c_new = sc;
            v_new = fv;
        end
        cmp = (op >= 4'h8) && (op <= 4'hB);
        res = pass ? r : 32'h0;
        wb  = pass && !cmp;
        nf  = (pass && (s || cmp)) ? {r[31], (r == 32'h0), c_new, v_new} : f;
    endfunction

    // ------------------------------------------------------------------
    // Directed vector table (flags carry over from row to row)
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  op;
        logic        s;
        logic [3:0]  cd;
        logic [31:0] a;
        logic [31:0] b;
        logic        sc;
        logic [3:0]  rd;
        logic [31:0] exp_res;
        logic        exp_wb;
        logic [3:0]  exp_flags;
    } vec_t;

    localparam int num_vecs = 19;
    vec_t vecs[num_vecs];

    // Scoreboard for the random phase: {wb_en, wb_addr, result}
    logic [36:0] exp_q[$];
    logic [3:0]  mdl_flags;

    initial begin
        vecs[0]  = '{4'h4, 1'b1, 4'hE, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd3,  32'h80000000, 1'b1, 4'b1001}; // ADDS overflow
        vecs[1]  = '{4'h2, 1'b1, 4'hE, 32'h00000005, 32'h00000005, 1'b0, 4'd4,  32'h00000000, 1'b1, 4'b0110}; // SUBS 5-5
        vecs[2]  = '{4'hA, 1'b0, 4'hE, 32'h00000003, 32'h00000004, 1'b0, 4'd5,  32'hFFFFFFFF, 1'b0, 4'b1000}; // CMP 3,4
        vecs[3]  = '{4'hA, 1'b0, 4'hE, 32'h00000003, 32'h00000003, 1'b0, 4'd6,  32'h00000000, 1'b0, 4'b0110}; // CMP 3,3
        vecs[4]  = '{4'h4, 1'b0, 4'h0, 32'h00000010, 32'h00000020, 1'b0, 4'd7,  32'h00000030, 1'b1, 4'b0110}; // ADDEQ passes
        vecs[5]  = '{4'h4, 1'b0, 4'h1, 32'h00000001, 32'h00000002, 1'b0, 4'd8,  32'h00000000, 1'b0, 4'b0110}; // ADDNE fails
        vecs[6]  = '{4'h4, 1'b1, 4'hE, 32'h7FFFFFFF, 32'h00000001, 1'b0, 4'd9,  32'h80000000, 1'b1, 4'b1001}; // set V
        vecs[7]  = '{4'hD, 1'b1, 4'hE, 32'h00000000, 32'h00000000, 1'b1, 4'd10, 32'h00000000, 1'b1, 4'b0111}; // MOVS keeps V
        vecs[8]  = '{4'h4, 1'b0, 4'hF, 32'h00000001, 32'h00000002, 1'b0, 4'd11, 32'h00000000, 1'b0, 4'b0111}; // cond 0xF
        vecs[9]  = '{4'h5, 1'b1, 4'hE, 32'h00000001, 32'h00000001, 1'b0, 4'd12, 32'h00000003, 1'b1, 4'b0000}; // ADCS C=1
        vecs[10] = '{4'h6, 1'b1, 4'hE, 32'h00000005, 32'h00000003, 1'b0, 4'd13, 32'h00000001, 1'b1, 4'b0010}; // SBCS C=0
        vecs[11] = '{4'h3, 1'b1, 4'hE, 32'h00000001, 32'h00000000, 1'b0, 4'd14, 32'hFFFFFFFF, 1'b1, 4'b1000}; // RSBS 0-1
        vecs[12] = '{4'h1, 1'b1, 4'hE, 32'h000000F0, 32'h000000FF, 1'b0, 4'd1,  32'h0000000F, 1'b1, 4'b0000}; // EORS
        vecs[13] = '{4'hE, 1'b0, 4'hE, 32'h000000FF, 32'h0000000F, 1'b0, 4'd2,  32'h000000F0, 1'b1, 4'b0000}; // BIC
        vecs[14] = '{4'hF, 1'b1, 4'hE, 32'h00000000, 32'h00000000, 1'b1, 4'd3,  32'hFFFFFFFF, 1'b1, 4'b1010}; // MVNS
        vecs[15] = '{4'h9, 1'b0, 4'hE, 32'h00000005, 32'h00000005, 1'b0, 4'd4,  32'h00000000, 1'b0, 4'b0100}; // TEQ equal
        vecs[16] = '{4'hC, 1'b0, 4'hC, 32'h00000001, 32'h00000002, 1'b0, 4'd5,  32'h00000000, 1'b0, 4'b0100}; // ORRGT fails
        vecs[17] = '{4'hC, 1'b0, 4'h9, 32'h00000001, 32'h00000002, 1'b0, 4'd6,  32'h00000003, 1'b1, 4'b0100}; // ORRLS passes
        vecs[18] = '{4'hB, 1'b0, 4'hE, 32'hFFFFFFFF, 32'h00000001, 1'b0, 4'd7,  32'h00000000, 1'b0, 4'b0110}; // CMN wrap

        // ---------------- reset ----------------
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive(4'h0, 1'b0, 4'hE, 32'h0, 32'h0, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        chk("reset_in_ready",  in_ready,  1'b0);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_flags",     flags,     4'b0000);
        chk("reset_result",    result,    32'h0);
        chk("reset_wb_en",     wb_en,     1'b0);
        chk("reset_wb_addr",   wb_addr,   4'd0);
        rst = 1'b0;

        // ---------------- directed table ----------------
        for (int i = 0; i < num_vecs; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].s, vecs[i].cd, vecs[i].a, vecs[i].b, vecs[i].sc, vecs[i].rd);
            in_valid = 1'b1;
            #1;
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_result", i),    result,    vecs[i].exp_res);
            chk($sformatf("vec%0d_wb_en", i),     wb_en,     vecs[i].exp_wb);
            chk($sformatf("vec%0d_wb_addr", i),   wb_addr,   vecs[i].rd);
            chk($sformatf("vec%0d_flags", i),     flags,     vecs[i].exp_flags);
        end

        // ---------------- stall, then drain and accept on one edge ----------------
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'hD, 1'b0, 4'hE, 32'h0, 32'h0000AAAA, 1'b0, 4'd5);
        in_valid = 1'b1;
        @(negedge clk);
        drive(4'hD, 1'b0, 4'hE, 32'h0, 32'h00005555, 1'b0, 4'd6);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready",  in_ready,  1'b0);
            chk("stall_out_valid", out_valid, 1'b1);
            chk("stall_result",    result,    32'h0000AAAA);
            chk("stall_wb_en",     wb_en,     1'b1);
            chk("stall_wb_addr",   wb_addr,   4'd5);
        end
        out_ready = 1'b1;
        #1;
        chk("drain_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("drain_out_valid", out_valid, 1'b1);
        chk("drain_result",    result,    32'h00005555);
        chk("drain_wb_addr",   wb_addr,   4'd6);

        // ---------------- reset during a stall ----------------
        @(negedge clk);
        drive(4'h4, 1'b1, 4'hE, 32'h80000000, 32'h80000000, 1'b0, 4'd1);
        in_valid = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        drive(4'hD, 1'b0, 4'hE, 32'h0, 32'h00001234, 1'b0, 4'd2);
        chk("pre_rst_flags",     flags,     4'b0111);
        chk("pre_rst_out_valid", out_valid, 1'b1);
        @(negedge clk);
        chk("pre_rst_in_ready", in_ready, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_in_ready", in_ready, 1'b0);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_flags",     flags,     4'b0000);
        chk("rst_result",    result,    32'h0);
        chk("rst_wb_en",     wb_en,     1'b0);
        chk("rst_wb_addr",   wb_addr,   4'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready",  in_ready,  1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);
        in_valid = 1'b0;

        // ---------------- random phase ----------------
        mdl_flags = 4'b0000;
        for (int cyc = 0; cyc < 800; cyc++) begin
            logic        exp_ready;
            logic [31:0] r_res;
            logic        r_wb;
            logic [3:0]  r_nf;
            logic [31:0] ra, rb;
            @(negedge clk);
            chk("rand_flags",     flags,     mdl_flags);
            chk("rand_out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0)
                chk("rand_entry", {wb_en, wb_addr, result}, exp_q[0]);

            case ($urandom_range(0, 5))
                0:       ra = 32'h00000000;
                1:       ra = 32'h7FFFFFFF;
                2:       ra = 32'h80000000;
                3:       ra = 32'hFFFFFFFF;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 5))
                0:       rb = 32'h00000000;
                1:       rb = 32'h00000001;
                2:       rb = 32'h80000000;
                3:       rb = ra;
                default: rb = $urandom;
            endcase
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  ra, rb, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = (exp_q.size() == 0) || out_ready;
            chk("rand_in_ready", in_ready, exp_ready);

            // Predict the coming edge: drain first, then accept.
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
            if (in_valid && exp_ready) begin
                ref_model(opcode, s_bit, cond, rn_val, operand2, shift_carry, mdl_flags,
                          r_res, r_wb, r_nf);
                exp_q.push_back({r_wb, rd_addr, r_res});
                mdl_flags = r_nf;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk("final_flags", flags, mdl_flags);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
